// File: rtl/mmu_ice40_pkg.sv
// mmu_ice40_pkg -- shared types and helpers for the iCE40 memory unit.
// Turns the mmu_map.vh constants into typed localparams, defines the
// registered load-source encoding and the load alignment / byte-mask helpers.
package mmu_ice40_pkg;
`include "mmu_map.vh"

   localparam logic [31:0] RAM_BASE       = `MMU_RAM_BASE;
   localparam logic [31:0] IO_BASE        = `MMU_IO_BASE;
   localparam logic [31:0] ADDR_MTIME_LO  = IO_BASE + `MMU_OFF_MTIME_LO;
   localparam logic [31:0] ADDR_MTIME_HI  = IO_BASE + `MMU_OFF_MTIME_HI;
   localparam logic [31:0] ADDR_MTCMP_LO  = IO_BASE + `MMU_OFF_MTIMECMP_LO;
   localparam logic [31:0] ADDR_MTCMP_HI  = IO_BASE + `MMU_OFF_MTIMECMP_HI;
   localparam logic [31:0] ADDR_GPIO_OUT  = IO_BASE + `MMU_OFF_GPIO_OUT;
   localparam logic [31:0] ADDR_GPIO_IN   = IO_BASE + `MMU_OFF_GPIO_IN;

   localparam logic [3:0]  BE_NONE = `MMU_BE_NONE;
   localparam logic [3:0]  BE_BYTE = `MMU_BE_BYTE;
   localparam logic [3:0]  BE_HALF = `MMU_BE_HALF;
   localparam logic [3:0]  BE_WORD = `MMU_BE_WORD;

   // Where the registered load result comes from in the cycle after the address.
   typedef enum logic [1:0] {
      LD_NONE = 2'd0,
      LD_RAM  = 2'd1,
      LD_IO   = 2'd2
   } ld_src_e;

   // Right-align the addressed lanes and extend to 32 bits.
   function automatic logic [31:0] load_align(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [3:0]  be,
                                              input logic        sgn);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (be)
         BE_BYTE: load_align = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
         BE_HALF: load_align = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
         BE_WORD: load_align = sh;
         default: load_align = 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] byte_mask(input logic [3:0] be);
      byte_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/mmu_map.vh
// mmu_map.vh -- memory map shared by the RTL and core-side software tests.
// Holds the RAM and I/O base addresses, the I/O register byte offsets and
// the dm_be access-size encodings. Plain `defines so that non-SV tooling
// can consume the same file.
`ifndef MMU_MAP_VH
`define MMU_MAP_VH

`define MMU_RAM_BASE        32'h0000_0000
`define MMU_IO_BASE         32'h8000_0000

`define MMU_OFF_MTIME_LO    32'h0000_0000
`define MMU_OFF_MTIME_HI    32'h0000_0004
`define MMU_OFF_MTIMECMP_LO 32'h0000_0008
`define MMU_OFF_MTIMECMP_HI 32'h0000_000C
`define MMU_OFF_GPIO_OUT    32'h0000_0010
`define MMU_OFF_GPIO_IN     32'h0000_0014

`define MMU_BE_NONE         4'b0000
`define MMU_BE_BYTE         4'b0001
`define MMU_BE_HALF         4'b0011
`define MMU_BE_WORD         4'b1111

`endif

// File: rtl/mmu_timer.sv
// mmu_timer -- 64-bit free-running mtime, mtimecmp and the timer interrupt.
// Ports:
//   clk, resetb        clock, synchronous active-low reset
//   we, widx           write strobe; word index 0=MTIME_LO 1=MTIME_HI
//                      2=MTIMECMP_LO 3=MTIMECMP_HI
//   wbe, wdata         lane-aligned byte enables and write data
//   mtime, mtimecmp    current register values (for reads)
//   irq                registered (mtime >= mtimecmp), unsigned 64-bit
module mmu_timer
   import mmu_ice40_pkg::*;
(
   input  logic        clk,
   input  logic        resetb,
   input  logic        we,
   input  logic [1:0]  widx,
   input  logic [3:0]  wbe,
   input  logic [31:0] wdata,
   output logic [63:0] mtime,
   output logic [63:0] mtimecmp,
   output logic        irq
);

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] cmp_q, cmp_d;
   logic        irq_q, irq_d;
   logic [63:0] inc;
   logic [31:0] m;

   // A store replaces only the enabled bytes of the word it targets; the other
   // word keeps its incremented value, so a carry out of a written low word is
   // taken from the pre-write count.
   always_comb begin
      m       = byte_mask(wbe);
      inc     = mtime_q + 64'd1;
      mtime_d = inc;
      cmp_d   = cmp_q;
      irq_d   = (mtime_q >= cmp_q);
      if (we) begin
         case (widx)
            2'd0:    mtime_d[31:0]  = (inc[31:0]    & ~m) | (wdata & m);
            2'd1:    mtime_d[63:32] = (inc[63:32]   & ~m) | (wdata & m);
            2'd2:    cmp_d[31:0]    = (cmp_q[31:0]  & ~m) | (wdata & m);
            default: cmp_d[63:32]   = (cmp_q[63:32] & ~m) | (wdata & m);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         mtime_q <= '0;
         cmp_q   <= '1;
         irq_q   <= 1'b0;
      end else begin
         mtime_q <= mtime_d;
         cmp_q   <= cmp_d;
         irq_q   <= irq_d;
      end
   end

   assign mtime    = mtime_q;
   assign mtimecmp = cmp_q;
   assign irq      = irq_q;

endmodule

// File: rtl/mmu_ice40.sv
// mmu_ice40 -- unified RAM + memory-mapped timer/GPIO for an iCE40 RISC-V core.
// Optional feature macro: MMU_TIMER_EN (includes mtime/mtimecmp; without it
// the timer addresses read 0, ignore stores, and irq_mtimecmp is 0).
// Ports:
//   clk, resetb               clock, synchronous active-low reset
//   im_addr -> im_do          instruction fetch, 1-cycle synchronous read
//   dm_addr, dm_di, dm_we,    data access; dm_be gives size (byte/half/word),
//   dm_be, dm_is_signed       dm_di right-aligned, loads extended per sign
//   dm_do                     load data, valid the cycle after the address
//   gpio_out / gpio_in        GPIO output register / synchronised input pins
//   irq_mtimecmp              timer interrupt request
module mmu_ice40
   import mmu_ice40_pkg::*;
#(
   parameter int RAM_WORDS = 2048,
   parameter     INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic [31:0] im_addr,
   output logic [31:0] im_do,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_di,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic        dm_is_signed,
   output logic [31:0] dm_do,
   output logic [7:0]  gpio_out,
   input  logic [7:0]  gpio_in,
   output logic        irq_mtimecmp
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

   // EBR: port A read-only (fetch), port B read/write (data), both read-first.
   logic [31:0] mem [RAM_WORDS];
   logic [31:0] ram_a_q, ram_b_q;

   logic [AW-1:0] im_idx, dm_idx;
   logic [31:0]   dm_word, di_sh, io_rd_d, io_rd_q;
   logic [3:0]    be_sh;
   logic          im_hit, dm_hit, access, store, ram_we;
   logic          is_mtlo, is_mthi, is_cmplo, is_cmphi, is_gpo, is_gpi, io_hit;
   logic [63:0]   mtime, mtimecmp;
   ld_src_e       ld_src_q, ld_src_d;
   logic [1:0]    ld_off_q, ld_off_d;
   logic [3:0]    ld_be_q, ld_be_d;
   logic          ld_sgn_q, ld_sgn_d;
   logic          im_vld_q, im_vld_d;
   logic [7:0]    gpio_out_q, gpio_out_d;
   logic [7:0]    gpio_s1_q, gpio_s1_d, gpio_s2_q, gpio_s2_d;

   assign im_idx = im_addr[AW+1:2];
   assign dm_idx = dm_addr[AW+1:2];

   always_comb begin
      im_hit   = (im_addr - RAM_BASE) < RAM_BYTES;
      dm_hit   = (dm_addr - RAM_BASE) < RAM_BYTES;
      dm_word  = {dm_addr[31:2], 2'b00};
      is_mtlo  = (dm_word == ADDR_MTIME_LO);
      is_mthi  = (dm_word == ADDR_MTIME_HI);
      is_cmplo = (dm_word == ADDR_MTCMP_LO);
      is_cmphi = (dm_word == ADDR_MTCMP_HI);
      is_gpo   = (dm_word == ADDR_GPIO_OUT);
      is_gpi   = (dm_word == ADDR_GPIO_IN);
      io_hit   = is_mtlo | is_mthi | is_cmplo | is_cmphi | is_gpo | is_gpi;
      access   = (dm_be != BE_NONE);
      store    = dm_we && access && resetb;
      // Lanes beyond byte 3 fall off: accesses never span two words.
      be_sh    = 4'({4'b0000, dm_be} << dm_addr[1:0]);
      di_sh    = dm_di << {dm_addr[1:0], 3'b000};
      ram_we   = store && dm_hit;

      gpio_out_d = gpio_out_q;
      if (store && is_gpo && be_sh[0])
         gpio_out_d = di_sh[7:0];

      ld_src_d = LD_NONE;
      if (access && !dm_we) begin
         if (dm_hit)
            ld_src_d = LD_RAM;
         else if (io_hit)
            ld_src_d = LD_IO;
      end
      ld_off_d = dm_addr[1:0];
      ld_be_d  = dm_be;
      ld_sgn_d = dm_is_signed;

      // I/O reads are captured in the address cycle, like the RAM read.
      io_rd_d = 32'h0;
      if (is_mtlo)  io_rd_d = mtime[31:0];
      if (is_mthi)  io_rd_d = mtime[63:32];
      if (is_cmplo) io_rd_d = mtimecmp[31:0];
      if (is_cmphi) io_rd_d = mtimecmp[63:32];
      if (is_gpo)   io_rd_d = {24'h0, gpio_out_q};
      if (is_gpi)   io_rd_d = {24'h0, gpio_s2_q};

      im_vld_d  = im_hit;
      gpio_s1_d = gpio_in;
      gpio_s2_d = gpio_s1_q;
   end

`ifdef MMU_TIMER_EN
   logic timer_we;
   assign timer_we = store && (is_mtlo | is_mthi | is_cmplo | is_cmphi);

   mmu_timer u_timer (
      .clk      (clk),
      .resetb   (resetb),
      .we       (timer_we),
      .widx     (dm_addr[3:2]),
      .wbe      (be_sh),
      .wdata    (di_sh),
      .mtime    (mtime),
      .mtimecmp (mtimecmp),
      .irq      (irq_mtimecmp)
   );
`else
   assign mtime        = '0;
   assign mtimecmp     = '0;
   assign irq_mtimecmp = 1'b0;
`endif

   always_ff @(posedge clk) begin
      ram_a_q <= mem[im_idx];
      ram_b_q <= mem[dm_idx];
      for (int b = 0; b < 4; b++)
         if (ram_we && be_sh[b])
            mem[dm_idx][8*b +: 8] <= di_sh[8*b +: 8];
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         ld_src_q   <= LD_NONE;
         ld_off_q   <= 2'b00;
         ld_be_q    <= 4'b0000;
         ld_sgn_q   <= 1'b0;
         io_rd_q    <= 32'h0;
         im_vld_q   <= 1'b0;
         gpio_out_q <= 8'h00;
         gpio_s1_q  <= 8'h00;
         gpio_s2_q  <= 8'h00;
      end else begin
         ld_src_q   <= ld_src_d;
         ld_off_q   <= ld_off_d;
         ld_be_q    <= ld_be_d;
         ld_sgn_q   <= ld_sgn_d;
         io_rd_q    <= io_rd_d;
         im_vld_q   <= im_vld_d;
         gpio_out_q <= gpio_out_d;
         gpio_s1_q  <= gpio_s1_d;
         gpio_s2_q  <= gpio_s2_d;
      end
   end

   always_comb begin
      dm_do = 32'h0;
      case (ld_src_q)
         LD_RAM:  dm_do = load_align(ram_b_q, ld_off_q, ld_be_q, ld_sgn_q);
         LD_IO:   dm_do = load_align(io_rd_q, ld_off_q, ld_be_q, ld_sgn_q);
         default: dm_do = 32'h0;
      endcase
   end

   assign im_do    = im_vld_q ? ram_a_q : 32'h0;
   assign gpio_out = gpio_out_q;

endmodule
